// File: rtl/axi_riscv_atomics_sram_pkg.sv
// Shared definitions for the AXI-to-SRAM terminal slave.
//   - FSM state encoding (IDLE, WRITE, WRESP, READ)
//   - AXI response and burst-type constants
//   - next_addr(): per-beat address advance for FIXED / INCR bursts
package axi_riscv_atomics_sram_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_WRESP = 2'd2;
   localparam logic [1:0] ST_READ  = 2'd3;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   // Computed at 64 bits; callers truncate to their address width, which
   // gives the modulo-2^width wrap of the incrementing address for free.
   // WRAP bursts never reach memory, so they are advanced like INCR.
   function automatic logic [63:0] next_addr(input logic [63:0] addr,
                                             input logic [2:0]  size,
                                             input logic [1:0]  burst);
      logic [63:0] step;
      step = 64'd1 << size;
      if (burst == BURST_FIXED) begin
         return addr;
      end
      return (addr & ~(step - 64'd1)) + step;
   endfunction

endpackage

// File: rtl/axi_riscv_atomics_sram_addr_gen.sv
// Burst address generator.
// Latches the burst parameters on i_load and advances the address and beat
// count on every i_step.
//   i_load  : capture i_addr/i_len/i_size/i_burst, clear the beat count
//   i_step  : one beat consumed, move to the next address
//   o_addr  : byte address of the current beat
//   o_last  : current beat is the final one of the burst (count == len)
module axi_riscv_atomics_sram_addr_gen
   import axi_riscv_atomics_sram_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      i_load,
   input  logic [AXI_ADDR_WIDTH-1:0] i_addr,
   input  logic [7:0]                i_len,
   input  logic [2:0]                i_size,
   input  logic [1:0]                i_burst,
   input  logic                      i_step,
   output logic [AXI_ADDR_WIDTH-1:0] o_addr,
   output logic                      o_last
);

   logic [AXI_ADDR_WIDTH-1:0] r_addr;
   logic [7:0]                r_len;
   logic [7:0]                r_cnt;
   logic [2:0]                r_size;
   logic [1:0]                r_burst;
   logic [63:0]               w_next_full;
   logic                      w_unused;

   assign w_next_full = next_addr(64'(r_addr), r_size, r_burst);
   // Upper bits beyond the address width are intentionally dropped.
   assign w_unused    = ^w_next_full;

   assign o_addr = r_addr;
   assign o_last = (r_cnt == r_len);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= '0;
      end else if (i_step) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (i_load) begin
         r_addr  <= i_addr;
         r_len   <= i_len;
         r_size  <= i_size;
         r_burst <= i_burst;
      end else if (i_step) begin
         r_addr  <= w_next_full[AXI_ADDR_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/axi_riscv_atomics_sram_slv.sv
// AXI4 terminal slave in front of a single-port SRAM.
// Serves one burst at a time with round-robin AW/AR arbitration. Bursts that
// carry an ATOP or use WRAP are answered with SLVERR and never touch memory.
//   slv_aw_* / slv_w_* / slv_b_* : AXI write channels
//   slv_ar_* / slv_r_*           : AXI read channels
//   mem_*                        : SRAM port, read data returns one cycle
//                                  after a read mem_req_o
module axi_riscv_atomics_sram_slv
   import axi_riscv_atomics_sram_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 4,
   parameter int MEM_ADDR_WIDTH = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [AXI_ID_WIDTH-1:0]     slv_aw_id_i,
   input  logic [AXI_ADDR_WIDTH-1:0]   slv_aw_addr_i,
   input  logic [7:0]                  slv_aw_len_i,
   input  logic [2:0]                  slv_aw_size_i,
   input  logic [1:0]                  slv_aw_burst_i,
   input  logic [5:0]                  slv_aw_atop_i,
   input  logic                        slv_aw_valid_i,
   output logic                        slv_aw_ready_o,
   input  logic [AXI_DATA_WIDTH-1:0]   slv_w_data_i,
   input  logic [AXI_DATA_WIDTH/8-1:0] slv_w_strb_i,
   input  logic                        slv_w_last_i,
   input  logic                        slv_w_valid_i,
   output logic                        slv_w_ready_o,
   output logic [AXI_ID_WIDTH-1:0]     slv_b_id_o,
   output logic [1:0]                  slv_b_resp_o,
   output logic                        slv_b_valid_o,
   input  logic                        slv_b_ready_i,
   input  logic [AXI_ID_WIDTH-1:0]     slv_ar_id_i,
   input  logic [AXI_ADDR_WIDTH-1:0]   slv_ar_addr_i,
   input  logic [7:0]                  slv_ar_len_i,
   input  logic [2:0]                  slv_ar_size_i,
   input  logic [1:0]                  slv_ar_burst_i,
   input  logic                        slv_ar_valid_i,
   output logic                        slv_ar_ready_o,
   output logic [AXI_ID_WIDTH-1:0]     slv_r_id_o,
   output logic [AXI_DATA_WIDTH-1:0]   slv_r_data_o,
   output logic [1:0]                  slv_r_resp_o,
   output logic                        slv_r_last_o,
   output logic                        slv_r_valid_o,
   input  logic                        slv_r_ready_i,
   output logic                        mem_req_o,
   output logic                        mem_we_o,
   output logic [MEM_ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [AXI_DATA_WIDTH-1:0]   mem_wdata_o,
   output logic [AXI_DATA_WIDTH/8-1:0] mem_be_o,
   input  logic [AXI_DATA_WIDTH-1:0]   mem_rdata_i
);

   localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH/8;
   localparam int WORD_LSB       = $clog2(AXI_STRB_WIDTH);

   logic [1:0]                r_state;
   logic                      r_prio_w;
   logic                      r_active;
   logic                      r_err;
   logic [AXI_ID_WIDTH-1:0]   r_id;
   logic                      r_inflight;
   logic                      r_issued_last;
   logic                      r_rd_done;
   logic                      r_rvalid;
   logic                      r_rlast;
   logic [1:0]                r_rresp;
   logic [AXI_DATA_WIDTH-1:0] r_rdata;

   logic                      w_idle;
   logic                      w_aw_hs;
   logic                      w_ar_hs;
   logic                      w_wbeat;
   logic                      w_rissue;
   logic                      w_r_hs;
   logic                      w_ag_last;
   logic [AXI_ADDR_WIDTH-1:0] w_ag_addr;
   logic [AXI_ADDR_WIDTH-1:0] w_ld_addr;
   logic [7:0]                w_ld_len;
   logic [2:0]                w_ld_size;
   logic [1:0]                w_ld_burst;
   logic                      w_unused;

   // Hold off the address channels for the first cycle out of reset so that
   // no ready is ever seen while reset is asserted.
   assign w_idle = (r_state == ST_IDLE) && r_active;

   // Each ready is withheld only when the other channel is valid and owns
   // the priority, so exactly one side can handshake in a given cycle.
   assign slv_aw_ready_o = w_idle && !(slv_ar_valid_i && !r_prio_w);
   assign slv_ar_ready_o = w_idle && !(slv_aw_valid_i &&  r_prio_w);
   assign w_aw_hs = slv_aw_ready_o && slv_aw_valid_i;
   assign w_ar_hs = slv_ar_ready_o && slv_ar_valid_i;

   assign w_ld_addr  = w_aw_hs ? slv_aw_addr_i  : slv_ar_addr_i;
   assign w_ld_len   = w_aw_hs ? slv_aw_len_i   : slv_ar_len_i;
   assign w_ld_size  = w_aw_hs ? slv_aw_size_i  : slv_ar_size_i;
   assign w_ld_burst = w_aw_hs ? slv_aw_burst_i : slv_ar_burst_i;

   assign w_wbeat  = (r_state == ST_WRITE) && slv_w_valid_i;
   // One read beat in flight; the next is issued only once the R register
   // is free or being emptied this cycle.
   assign w_rissue = (r_state == ST_READ) && !r_inflight && !r_rd_done &&
                     (!r_rvalid || slv_r_ready_i);
   assign w_r_hs   = r_rvalid && slv_r_ready_i;

   axi_riscv_atomics_sram_addr_gen #(
      .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH)
   ) u_addr_gen (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_load  (w_aw_hs || w_ar_hs),
      .i_addr  (w_ld_addr),
      .i_len   (w_ld_len),
      .i_size  (w_ld_size),
      .i_burst (w_ld_burst),
      .i_step  (w_wbeat || w_rissue),
      .o_addr  (w_ag_addr),
      .o_last  (w_ag_last)
   );

   // Burst length alone ends a write; w_last carries no extra information.
   assign w_unused = ^{slv_w_last_i, w_ag_addr};

   assign mem_req_o   = (w_wbeat || w_rissue) && !r_err;
   assign mem_we_o    = w_wbeat && !r_err;
   assign mem_addr_o  = w_ag_addr[WORD_LSB +: MEM_ADDR_WIDTH];
   assign mem_wdata_o = slv_w_data_i;
   assign mem_be_o    = slv_w_strb_i;

   assign slv_w_ready_o = (r_state == ST_WRITE);
   assign slv_b_valid_o = (r_state == ST_WRESP);
   assign slv_b_resp_o  = ((r_state == ST_WRESP) && r_err) ? RESP_SLVERR : RESP_OKAY;
   assign slv_b_id_o    = r_id;

   assign slv_r_valid_o = r_rvalid;
   assign slv_r_last_o  = r_rlast;
   assign slv_r_resp_o  = r_rresp;
   assign slv_r_data_o  = r_rdata;
   assign slv_r_id_o    = r_id;

   // Stage: request/grant FSM
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= ST_IDLE;
         r_prio_w <= 1'b1;
         r_active <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_active <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (w_aw_hs) begin
                  r_state  <= ST_WRITE;
                  r_prio_w <= 1'b0;
                  r_err    <= (slv_aw_atop_i != 6'd0) || (slv_aw_burst_i == BURST_WRAP);
               end else if (w_ar_hs) begin
                  r_state  <= ST_READ;
                  r_prio_w <= 1'b1;
                  r_err    <= (slv_ar_burst_i == BURST_WRAP);
               end
            end
            ST_WRITE: if (w_wbeat && w_ag_last)     r_state <= ST_WRESP;
            ST_WRESP: if (slv_b_ready_i)            r_state <= ST_IDLE;
            ST_READ:  if (w_r_hs && r_rlast)        r_state <= ST_IDLE;
            default:                                r_state <= ST_IDLE;
         endcase
      end
   end

   // Stage: read issue -> R output register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_inflight    <= 1'b0;
         r_issued_last <= 1'b0;
         r_rd_done     <= 1'b0;
         r_rvalid      <= 1'b0;
         r_rlast       <= 1'b0;
         r_rresp       <= RESP_OKAY;
      end else begin
         if (w_ar_hs) begin
            r_rd_done <= 1'b0;
         end
         if (w_rissue) begin
            r_inflight    <= 1'b1;
            r_issued_last <= w_ag_last;
            if (w_ag_last) begin
               r_rd_done <= 1'b1;
            end
         end
         if (w_r_hs) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
         end
         // Landing cannot coincide with a handshake: an issue empties R first.
         if (r_inflight) begin
            r_inflight <= 1'b0;
            r_rvalid   <= 1'b1;
            r_rlast    <= r_issued_last;
            r_rresp    <= r_err ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_aw_hs) begin
         r_id <= slv_aw_id_i;
      end else if (w_ar_hs) begin
         r_id <= slv_ar_id_i;
      end
      if (r_inflight) begin
         r_rdata <= r_err ? '0 : mem_rdata_i;
      end
   end

endmodule

// File: tb/tb_axi_riscv_atomics_sram_slv.sv
module tb_axi_riscv_atomics_sram_slv;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  aw_id, ar_id, b_id, r_id;
   logic [31:0] aw_addr, ar_addr;
   logic [7:0]  aw_len, ar_len, w_strb, mem_be;
   logic [2:0]  aw_size, ar_size;
   logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
   logic [5:0]  aw_atop;
   logic        aw_valid, aw_ready, ar_valid, ar_ready, w_last, w_valid, w_ready;
   logic        b_valid, b_ready, r_last, r_valid, r_ready, mem_req, mem_we;
   logic [63:0] w_data, r_data, mem_wdata, mem_rdata;
   logic [15:0] mem_addr;

   always #5 clk = ~clk;

   axi_riscv_atomics_sram_slv dut (
      .clk_i(clk), .rst_ni(rst_n),
      .slv_aw_id_i(aw_id), .slv_aw_addr_i(aw_addr), .slv_aw_len_i(aw_len),
      .slv_aw_size_i(aw_size), .slv_aw_burst_i(aw_burst), .slv_aw_atop_i(aw_atop),
      .slv_aw_valid_i(aw_valid), .slv_aw_ready_o(aw_ready),
      .slv_w_data_i(w_data), .slv_w_strb_i(w_strb), .slv_w_last_i(w_last),
      .slv_w_valid_i(w_valid), .slv_w_ready_o(w_ready),
      .slv_b_id_o(b_id), .slv_b_resp_o(b_resp), .slv_b_valid_o(b_valid), .slv_b_ready_i(b_ready),
      .slv_ar_id_i(ar_id), .slv_ar_addr_i(ar_addr), .slv_ar_len_i(ar_len),
      .slv_ar_size_i(ar_size), .slv_ar_burst_i(ar_burst),
      .slv_ar_valid_i(ar_valid), .slv_ar_ready_o(ar_ready),
      .slv_r_id_o(r_id), .slv_r_data_o(r_data), .slv_r_resp_o(r_resp),
      .slv_r_last_o(r_last), .slv_r_valid_o(r_valid), .slv_r_ready_i(r_ready),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
   );

   // SRAM the DUT talks to
   logic [63:0] sram [0:65535];
   always @(posedge clk) begin
      if (mem_req === 1'b1) begin
         if (mem_we) begin
            for (int b = 0; b < 8; b++)
               if (mem_be[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
         end else begin
            mem_rdata <= sram[mem_addr];
         end
      end
   end

   typedef struct { bit we; int addr; logic [63:0] wdata; logic [7:0] be; } acc_t;
   acc_t acc_q[$];
   always @(negedge clk)
      if (mem_req === 1'b1) acc_q.push_back('{mem_we, int'(mem_addr), mem_wdata, mem_be});

   // Reference model: word-level shadow memory plus address arithmetic
   logic [63:0] ref_mem [0:65535];

   typedef struct {
      bit wr; logic [3:0] id; logic [31:0] addr; logic [7:0] len; logic [2:0] size;
      logic [1:0] burst; logic [5:0] atop; logic [7:0] strb;
      logic [1:0] exp_resp; int exp_nacc;
   } vec_t;

   int n_chk = 0, n_fail = 0;
   string cur = "init";

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s/%s: got %h, expected %h", cur, name, act, exp);
      end
   endtask

   function automatic int beat_word(input logic [31:0] addr, input logic [2:0] size,
                                    input logic [1:0] burst, input int beat);
      longint unsigned a = 64'(addr);
      longint unsigned step = 64'd1 << size;
      for (int i = 0; i < beat; i++)
         if (burst == 2'b01) a = ((a / step) * step + step) % 64'h1_0000_0000;
      return int'((a / 8) % 65536);
   endfunction

   function automatic logic [63:0] wdata_of(input logic [63:0] seed, input int beat);
      return seed + 64'(beat) * 64'h0101_0101_0101_0101;
   endfunction

   function automatic bit rdy(input int which);
      case (which)
         0: return aw_ready === 1'b1;
         1: return ar_ready === 1'b1;
         2: return w_ready === 1'b1;
         default: return b_valid === 1'b1;
      endcase
   endfunction

   // Waits (sampling on negedge) for a ready/valid; returns at negedge.
   task automatic wait_neg(input int which, input string name);
      int n = 0;
      @(negedge clk);
      while (!rdy(which) && n < 100) begin @(negedge clk); n++; end
      if (!rdy(which)) begin
         n_chk++; n_fail++;
         $display("FAIL %s/%s_timeout: got 0, expected 1", cur, name);
      end
   endtask

   task automatic aw_issue(input vec_t v);
      aw_id = v.id; aw_addr = v.addr; aw_len = v.len; aw_size = v.size;
      aw_burst = v.burst; aw_atop = v.atop; aw_valid = 1'b1;
      wait_neg(0, "aw_ready");
      @(posedge clk); #1;
      aw_valid = 1'b0;
   endtask

   task automatic ar_issue(input vec_t v);
      ar_id = v.id; ar_addr = v.addr; ar_len = v.len; ar_size = v.size;
      ar_burst = v.burst; ar_valid = 1'b1;
      wait_neg(1, "ar_ready");
      @(posedge clk); #1;
      ar_valid = 1'b0;
   endtask

   task automatic w_beats(input vec_t v, input logic [63:0] seed, input bit gap);
      for (int b = 0; b <= int'(v.len); b++) begin
         if (gap) begin
            w_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         end
         w_data = wdata_of(seed, b); w_strb = v.strb; w_last = (b == int'(v.len));
         w_valid = 1'b1;
         wait_neg(2, "w_ready");
         @(posedge clk); #1;
      end
      w_valid = 1'b0; w_last = 1'b0;
   endtask

   task automatic b_collect(input vec_t v);
      b_ready = 1'b1;
      wait_neg(3, "b_valid");
      chk("b_id", 64'(b_id), 64'(v.id));
      chk("b_resp", 64'(b_resp), 64'(v.exp_resp));
      @(posedge clk); #1;
      b_ready = 1'b0;
   endtask

   task automatic ref_write(input vec_t v, input logic [63:0] seed);
      if (v.exp_resp != 2'b00) return;
      for (int b = 0; b <= int'(v.len); b++) begin
         int w = beat_word(v.addr, v.size, v.burst, b);
         logic [63:0] d = wdata_of(seed, b);
         for (int k = 0; k < 8; k++)
            if (v.strb[k]) ref_mem[w][k*8 +: 8] = d[k*8 +: 8];
      end
   endtask

   task automatic check_log(input vec_t v, input bit we, input logic [63:0] seed);
      chk("n_mem_req", 64'(acc_q.size()), 64'(v.exp_nacc));
      for (int i = 0; i < acc_q.size() && i < v.exp_nacc; i++) begin
         chk($sformatf("mem_addr%0d", i), 64'(acc_q[i].addr), 64'(beat_word(v.addr, v.size, v.burst, i)));
         chk($sformatf("mem_we%0d", i), 64'(acc_q[i].we), 64'(we));
         if (we) begin
            chk($sformatf("mem_wdata%0d", i), acc_q[i].wdata, wdata_of(seed, i));
            chk($sformatf("mem_be%0d", i), 64'(acc_q[i].be), 64'(v.strb));
         end
      end
   endtask

   // Collects len+1 R beats (optionally with random backpressure).
   task automatic r_collect(input vec_t v, input bit rand_ready);
      int beat = 0, cyc = 0;
      logic [63:0] exp_d;
      r_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      while (beat <= int'(v.len) && cyc < 300) begin
         @(negedge clk); cyc++;
         if (r_valid === 1'b1 && r_ready) begin
            exp_d = (v.exp_resp == 2'b00) ? ref_mem[beat_word(v.addr, v.size, v.burst, beat)] : 64'd0;
            chk($sformatf("r_data%0d", beat), r_data, exp_d);
            chk($sformatf("r_resp%0d", beat), 64'(r_resp), 64'(v.exp_resp));
            chk($sformatf("r_id%0d", beat), 64'(r_id), 64'(v.id));
            chk($sformatf("r_last%0d", beat), 64'(r_last), 64'(beat == int'(v.len)));
            if (beat == int'(v.len)) chk("ar_ready_in_read", 64'(ar_ready), 64'd0);
            beat++;
         end
         @(posedge clk); #1;
         if (rand_ready) r_ready = 1'($urandom_range(0, 1));
      end
      r_ready = 1'b0;
      if (beat <= int'(v.len)) begin
         n_chk++; n_fail++;
         $display("FAIL %s/r_timeout: got %0d beats, expected %0d", cur, beat, int'(v.len) + 1);
      end
   endtask

   task automatic run_write(input vec_t v, input logic [63:0] seed, input bit gap);
      acc_q.delete();
      aw_issue(v);
      w_beats(v, seed, gap);
      b_collect(v);
      check_log(v, 1'b1, seed);
      ref_write(v, seed);
   endtask

   task automatic run_read(input vec_t v, input bit rand_ready);
      acc_q.delete();
      ar_issue(v);
      r_collect(v, rand_ready);
      check_log(v, 1'b0, 64'd0);
      @(negedge clk);
      chk("aw_ready_after_read", 64'(aw_ready), 64'd1);
      @(posedge clk); #1;
   endtask

   vec_t vecs [10];

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v, w1, w2, r1;
      int bad;
      logic [63:0] d0;
      for (int i = 0; i < 65536; i++) begin sram[i] = 64'd0; ref_mem[i] = 64'd0; end
      aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0; aw_atop = 0; aw_valid = 0;
      ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0; ar_valid = 0;
      w_data = 0; w_strb = 0; w_last = 0; w_valid = 0; b_ready = 0; r_ready = 0;
      mem_rdata = 0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      cur = "reset";
      chk("aw_ready", 64'(aw_ready), 0); chk("ar_ready", 64'(ar_ready), 0);
      chk("w_ready", 64'(w_ready), 0);   chk("b_valid", 64'(b_valid), 0);
      chk("r_valid", 64'(r_valid), 0);   chk("mem_req", 64'(mem_req), 0);
      chk("b_resp", 64'(b_resp), 0);     chk("r_resp", 64'(r_resp), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      //            wr id    addr          len  sz   burst atop   strb   resp   nacc
      vecs[0] = '{1, 4'd3, 32'h10,       8'd3, 3'd3, 2'b01, 6'h00, 8'hFF, 2'b00, 4};
      vecs[1] = '{0, 4'd5, 32'h10,       8'd3, 3'd3, 2'b01, 6'h00, 8'hFF, 2'b00, 4};
      vecs[2] = '{1, 4'd6, 32'h30,       8'd0, 3'd3, 2'b01, 6'h20, 8'hFF, 2'b10, 0};
      vecs[3] = '{0, 4'd2, 32'h10,       8'd1, 3'd3, 2'b10, 6'h00, 8'hFF, 2'b10, 0};
      vecs[4] = '{1, 4'd1, 32'h08,       8'd2, 3'd3, 2'b00, 6'h00, 8'hFF, 2'b00, 3};
      vecs[5] = '{0, 4'd4, 32'h08,       8'd0, 3'd3, 2'b00, 6'h00, 8'hFF, 2'b00, 1};
      vecs[6] = '{1, 4'd7, 32'h1C,       8'd3, 3'd2, 2'b01, 6'h00, 8'hF0, 2'b00, 4};
      vecs[7] = '{0, 4'd8, 32'h18,       8'd3, 3'd3, 2'b01, 6'h00, 8'hFF, 2'b00, 4};
      vecs[8] = '{1, 4'd9, 32'hFFFFFFF8, 8'd1, 3'd3, 2'b01, 6'h00, 8'h3C, 2'b00, 2};
      vecs[9] = '{0, 4'hA, 32'hFFFFFFF8, 8'd1, 3'd3, 2'b01, 6'h00, 8'hFF, 2'b00, 2};

      for (int i = 0; i < 10; i++) begin
         cur = $sformatf("vec%0d", i);
         if (vecs[i].wr) run_write(vecs[i], 64'hA5C3_0000_1000_0000 + 64'(i) * 64'h100, 1'b0);
         else            run_read(vecs[i], 1'b0);
      end

      // Read with R held off: data must stay put and only one beat is fetched
      cur = "stall";
      v = '{0, 4'd1, 32'h10, 8'd1, 3'd3, 2'b01, 6'h00, 8'hFF, 2'b00, 2};
      acc_q.delete();
      ar_issue(v);
      r_ready = 1'b0;
      begin
         int n = 0;
         @(negedge clk);
         while (r_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      end
      chk("first_r_valid", 64'(r_valid), 64'd1);
      d0 = r_data;
      chk("first_r_data", d0, ref_mem[2]);
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (r_valid !== 1'b1 || r_data !== d0 || r_last !== 1'b0) bad++;
      end
      chk("stable_cycles_bad", 64'(bad), 64'd0);
      chk("mem_req_while_stalled", 64'(acc_q.size()), 64'd1);
      @(posedge clk); #1;
      r_collect(v, 1'b0);
      chk("mem_req_total", 64'(acc_q.size()), 64'd2);

      // Round-robin: both valid -> write first; then both valid again -> read
      cur = "rr";
      w1 = '{1, 4'd7, 32'h40, 8'd0, 3'd3, 2'b01, 6'h00, 8'hFF, 2'b00, 1};
      w2 = '{1, 4'd9, 32'h48, 8'd0, 3'd3, 2'b01, 6'h00, 8'hFF, 2'b00, 1};
      r1 = '{0, 4'd8, 32'h40, 8'd0, 3'd3, 2'b01, 6'h00, 8'hFF, 2'b00, 1};
      aw_id = w1.id; aw_addr = w1.addr; aw_len = w1.len; aw_size = w1.size;
      aw_burst = w1.burst; aw_atop = 0; aw_valid = 1'b1;
      ar_id = r1.id; ar_addr = r1.addr; ar_len = r1.len; ar_size = r1.size;
      ar_burst = r1.burst; ar_valid = 1'b1;
      @(negedge clk);
      chk("first_aw_ready", 64'(aw_ready), 64'd1);
      chk("first_ar_ready", 64'(ar_ready), 64'd0);
      @(posedge clk); #1;
      aw_valid = 1'b0;
      w_beats(w1, 64'h1111_2222_3333_4444, 1'b0);
      b_collect(w1);
      ref_write(w1, 64'h1111_2222_3333_4444);
      aw_id = w2.id; aw_addr = w2.addr; aw_len = w2.len; aw_size = w2.size;
      aw_burst = w2.burst; aw_valid = 1'b1;
      @(negedge clk);
      chk("second_ar_ready", 64'(ar_ready), 64'd1);
      chk("second_aw_ready", 64'(aw_ready), 64'd0);
      @(posedge clk); #1;
      ar_valid = 1'b0;
      r_collect(r1, 1'b0);
      aw_issue(w2);
      w_beats(w2, 64'h5555_6666_7777_8888, 1'b0);
      b_collect(w2);
      ref_write(w2, 64'h5555_6666_7777_8888);

      // Reset in the middle of a write burst
      cur = "midreset";
      v = '{1, 4'd3, 32'h800, 8'd3, 3'd3, 2'b01, 6'h00, 8'hFF, 2'b00, 4};
      aw_issue(v);
      w_data = 64'hDEAD_BEEF_0000_0001; w_strb = 8'hFF; w_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("outs_in_reset", 64'({aw_ready, ar_ready, w_ready, b_valid, r_valid, mem_req}), 64'd0);
      w_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      v = '{1, 4'd4, 32'h800, 8'd1, 3'd3, 2'b01, 6'h00, 8'hFF, 2'b00, 2};
      run_write(v, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0);
      v = '{0, 4'd5, 32'h800, 8'd1, 3'd3, 2'b01, 6'h00, 8'hFF, 2'b00, 2};
      run_read(v, 1'b0);

      // Randomized traffic against the shadow memory
      for (int i = 0; i < 40; i++) begin
         cur = $sformatf("rand%0d", i);
         v.wr = 1'($urandom_range(0, 1));
         v.id = 4'($urandom_range(0, 15));
         v.size = $urandom_range(0, 1) ? 3'd3 : 3'd2;
         v.addr = 32'($urandom_range(0, 31) * 8 + ((v.size == 3'd2) ? $urandom_range(0, 1) * 4 : 0));
         v.len = 8'($urandom_range(0, 7));
         v.burst = $urandom_range(0, 1) ? 2'b01 : 2'b00;
         v.atop = 6'd0;
         v.strb = 8'($urandom_range(1, 255));
         v.exp_resp = 2'b00;
         v.exp_nacc = int'(v.len) + 1;
         if (v.wr) run_write(v, {32'($urandom), 32'($urandom)}, 1'b1);
         else      run_read(v, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
